// File: rtl/perm_out_stream_if.sv
// Lane stream bundle leaving the permutation datapath.
// Master drives the lane beats; slave may stall with stopout.
interface perm_out_stream_if;
  logic        pushout;
  logic        stopout;
  logic        firstout;
  logic [63:0] dout;

  modport master (
    output pushout,
    output firstout,
    output dout,
    input  stopout
  );

  modport slave (
    input  pushout,
    input  firstout,
    input  dout,
    output stopout
  );
endinterface

// File: rtl/perm_out_stream.sv
// Streams finished Keccak lanes from lane memory, x-fastest order.
// One lane per beat under stopout backpressure; start/done bracket it.
module perm_out_stream #(
  parameter int NLANES = 25
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        startin,
  output logic        busy,
  output logic        done,
  output logic [2:0]  mrx,
  output logic [2:0]  mry,
  input  logic [63:0] mrd,
  perm_out_stream_if.master out
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  localparam logic [2:0] LX = 3'((NLANES - 1) % 5);
  localparam logic [2:0] LY = 3'((NLANES - 1) / 5);

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  x_q;
  logic [2:0]  y_q;
  logic        push_q;
  logic        first_q;
  logic        done_q;
  logic [63:0] dout_q;

  logic load;
  logic accept;
  logic last;
  logic origin;

  // Output register is free when empty or its beat leaves this edge.
  assign load   = !push_q || !out.stopout;
  assign accept = push_q && !out.stopout;
  assign last   = (x_q == LX) && (y_q == LY);
  assign origin = (x_q == 3'd0) && (y_q == 3'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (startin) state_d = STREAM;
      end
      STREAM: begin
        if (load && last) state_d = DRAIN;
      end
      DRAIN: begin
        if (accept) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    mrx  = 3'd0;
    mry  = 3'd0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      STREAM: begin
        busy = 1'b1;
        mrx  = x_q;
        mry  = y_q;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= 3'd0;
      y_q     <= 3'd0;
      push_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= 64'd0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        STREAM: begin
          if (load) begin
            dout_q  <= mrd;
            push_q  <= 1'b1;
            first_q <= origin;
            if (!last) begin
              if (x_q == 3'd4) begin
                x_q <= 3'd0;
                y_q <= y_q + 3'd1;
              end else begin
                x_q <= x_q + 3'd1;
              end
            end
          end
        end
        DRAIN: begin
          if (accept) begin
            push_q  <= 1'b0;
            first_q <= 1'b0;
            done_q  <= 1'b1;
            x_q     <= 3'd0;
            y_q     <= 3'd0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done         = done_q;
  assign out.pushout  = push_q;
  assign out.firstout = first_q;
  assign out.dout     = dout_q;

endmodule

// File: tb/tb_perm_out_stream.sv
// Scoreboard bench for perm_out_stream.
// Two instances: full 25-lane state and a 17-lane rate squeeze.
module tb_perm_out_stream;

  logic        clk;
  logic        rst;
  logic        start_a;
  logic        start_b;
  logic        busy_a;
  logic        busy_b;
  logic        done_a;
  logic        done_b;
  logic [2:0]  mrx_a;
  logic [2:0]  mry_a;
  logic [2:0]  mrx_b;
  logic [2:0]  mry_b;
  logic [63:0] mrd_a;
  logic [63:0] mrd_b;

  perm_out_stream_if if_a ();
  perm_out_stream_if if_b ();

  function automatic logic [63:0] lane(input int k);
    lane = {32'hA5A5_0000, 32'(k)};
  endfunction

  assign mrd_a = lane(5 * int'(mry_a) + int'(mrx_a));
  assign mrd_b = lane(5 * int'(mry_b) + int'(mrx_b));

  perm_out_stream #(.NLANES(25)) u_a (
    .clk     (clk),
    .rst     (rst),
    .startin (start_a),
    .busy    (busy_a),
    .done    (done_a),
    .mrx     (mrx_a),
    .mry     (mry_a),
    .mrd     (mrd_a),
    .out     (if_a)
  );

  perm_out_stream #(.NLANES(17)) u_b (
    .clk     (clk),
    .rst     (rst),
    .startin (start_b),
    .busy    (busy_b),
    .done    (done_b),
    .mrx     (mrx_b),
    .mry     (mry_b),
    .mrd     (mrd_b),
    .out     (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int cyc;
  int q[$];
  int done_cnt;
  int beats;

  logic        s_push;
  logic        s_first;
  logic        s_busy;
  logic        s_done;
  logic [63:0] s_dout;
  logic [2:0]  s_mrx;
  logic [2:0]  s_mry;

  // One cycle: drive, sample, scoreboard, advance to #1 after next edge.
  task automatic tick(input bit sel, input logic st,
                      input logic so, input logic r);
    int k;
    int nl;
    rst = r;
    start_a = sel ? 1'b0 : st;
    start_b = sel ? st : 1'b0;
    if_a.stopout = sel ? 1'b0 : so;
    if_b.stopout = sel ? so : 1'b0;
    nl = sel ? 17 : 25;
    if (sel) begin
      s_push  = if_b.pushout;
      s_first = if_b.firstout;
      s_dout  = if_b.dout;
      s_busy  = busy_b;
      s_done  = done_b;
      s_mrx   = mrx_b;
      s_mry   = mry_b;
    end else begin
      s_push  = if_a.pushout;
      s_first = if_a.firstout;
      s_dout  = if_a.dout;
      s_busy  = busy_a;
      s_done  = done_a;
      s_mrx   = mrx_a;
      s_mry   = mry_a;
    end
    if (!r && st && !s_busy) begin
      for (int i = 0; i < nl; i++) q.push_back(i);
    end
    n_checks++;
    if (s_first && !s_push) begin
      n_fail++;
      $display("FAIL first_no_push cyc %0d: got firstout=1 want 0",
               cyc);
    end
    if (s_done) begin
      done_cnt++;
      n_checks++;
      if (s_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL done_busy cyc %0d: got busy=%b want 0",
                 cyc, s_busy);
      end
    end
    if (sel && s_busy) begin
      n_checks++;
      if (5 * int'(s_mry) + int'(s_mrx) >= 17) begin
        n_fail++;
        $display("FAIL unread_lane cyc %0d: got x=%0d y=%0d want k<17",
                 cyc, s_mrx, s_mry);
      end
    end
    if (!r && s_push && !so) begin
      beats++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra cyc %0d: got dout=%h want none",
                 cyc, s_dout);
      end else begin
        k = q.pop_front();
        n_checks++;
        if (s_dout !== lane(k)) begin
          n_fail++;
          $display("FAIL sb_dout cyc %0d: got %h want %h",
                   cyc, s_dout, lane(k));
        end
        n_checks++;
        if (s_first !== 1'(k == 0)) begin
          n_fail++;
          $display("FAIL sb_first cyc %0d: got %b want %b",
                   cyc, s_first, k == 0);
        end
      end
    end
    if (r) q.delete();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic begin_test();
    cyc = 0;
    done_cnt = 0;
    beats = 0;
    q.delete();
  endtask

  task automatic check_sb_empty(input string name);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_sb_left: got %0d lanes pending want 0",
               name, q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_a = 1'($urandom);
      start_b = 1'($urandom);
      if_a.stopout = 1'($urandom);
      if_b.stopout = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    if_a.stopout = 1'b0;
    if_b.stopout = 1'b0;
    n_checks++;
    if ({busy_a, done_a, if_a.pushout, if_a.firstout,
         mrx_a, mry_a} !== 10'd0 || if_a.dout !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_a: got busy%b done%b push%b first%b x%0d y%0d d%h want 0",
               busy_a, done_a, if_a.pushout, if_a.firstout,
               mrx_a, mry_a, if_a.dout);
    end
    n_checks++;
    if ({busy_b, done_b, if_b.pushout, if_b.firstout,
         mrx_b, mry_b} !== 10'd0 || if_b.dout !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_b: got busy%b done%b push%b first%b x%0d y%0d d%h want 0",
               busy_b, done_b, if_b.pushout, if_b.firstout,
               mrx_b, mry_b, if_b.dout);
    end
    begin_test();
    for (int c = 0; c < 4; c++) begin
      tick(0, 1'b0, 1'($urandom), 1'b0);
      n_checks++;
      if (s_push !== 1'b0 || s_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got push=%b busy=%b want 0",
                 c, s_push, s_busy);
      end
    end
  endtask

  task automatic test_full_stream();
    begin_test();
    for (int c = 0; c <= 28; c++) begin
      tick(0, 1'(c == 0), 1'b0, 1'b0);
      n_checks++;
      if (s_push !== 1'(c >= 2 && c <= 26)) begin
        n_fail++;
        $display("FAIL full_push cyc %0d: got %b", c, s_push);
      end
      n_checks++;
      if (s_busy !== 1'(c >= 1 && c <= 26)) begin
        n_fail++;
        $display("FAIL full_busy cyc %0d: got %b", c, s_busy);
      end
      n_checks++;
      if (s_done !== 1'(c == 27)) begin
        n_fail++;
        $display("FAIL full_done cyc %0d: got %b", c, s_done);
      end
      n_checks++;
      if (s_first !== 1'(c == 2)) begin
        n_fail++;
        $display("FAIL full_first cyc %0d: got %b", c, s_first);
      end
      if (c == 26 || c == 27) begin
        n_checks++;
        if (s_dout !== lane(24)) begin
          n_fail++;
          $display("FAIL full_last_dout cyc %0d: got %h want %h",
                   c, s_dout, lane(24));
        end
      end
    end
    check_sb_empty("full");
  endtask

  task automatic test_backpressure();
    begin_test();
    for (int c = 0; c <= 31; c++) begin
      tick(0, 1'(c == 0), 1'(c >= 5 && c <= 7), 1'b0);
      if (c >= 5 && c <= 8) begin
        n_checks++;
        if (s_push !== 1'b1 || s_dout !== lane(3)) begin
          n_fail++;
          $display("FAIL bp_hold cyc %0d: got push=%b %h want %h",
                   c, s_push, s_dout, lane(3));
        end
      end
      if (c == 9 || c == 29) begin
        n_checks++;
        if (s_push !== 1'b1 ||
            s_dout !== lane(c == 9 ? 4 : 24)) begin
          n_fail++;
          $display("FAIL bp_beat cyc %0d: got push=%b %h",
                   c, s_push, s_dout);
        end
      end
      n_checks++;
      if (s_done !== 1'(c == 30)) begin
        n_fail++;
        $display("FAIL bp_done cyc %0d: got %b", c, s_done);
      end
    end
    n_checks++;
    if (beats != 25) begin
      n_fail++;
      $display("FAIL bp_beats: got %0d want 25", beats);
    end
    check_sb_empty("bp");
  endtask

  task automatic test_nlanes17();
    begin_test();
    for (int c = 0; c <= 21; c++) begin
      tick(1, 1'(c == 0), 1'b0, 1'b0);
      if (c == 18) begin
        n_checks++;
        if (s_push !== 1'b1 || s_dout !== 64'hA5A5_0000_0000_0010) begin
          n_fail++;
          $display("FAIL n17_last cyc %0d: got push=%b %h",
                   c, s_push, s_dout);
        end
      end
      n_checks++;
      if (s_done !== 1'(c == 19)) begin
        n_fail++;
        $display("FAIL n17_done cyc %0d: got %b", c, s_done);
      end
    end
    n_checks++;
    if (beats != 17) begin
      n_fail++;
      $display("FAIL n17_beats: got %0d want 17", beats);
    end
    check_sb_empty("n17");
  endtask

  task automatic test_start_handling();
    begin_test();
    for (int c = 0; c <= 56; c++) begin
      tick(0, 1'(c == 0 || c == 10 || c == 27), 1'b0, 1'b0);
      n_checks++;
      if (s_done !== 1'(c == 27 || c == 54)) begin
        n_fail++;
        $display("FAIL start_done cyc %0d: got %b", c, s_done);
      end
      n_checks++;
      if (s_first !== 1'(c == 2 || c == 29)) begin
        n_fail++;
        $display("FAIL start_first cyc %0d: got %b", c, s_first);
      end
      if (c == 29) begin
        n_checks++;
        if (s_dout !== lane(0)) begin
          n_fail++;
          $display("FAIL start_second cyc %0d: got %h want %h",
                   c, s_dout, lane(0));
        end
      end
    end
    n_checks++;
    if (beats != 50) begin
      n_fail++;
      $display("FAIL start_beats: got %0d want 50", beats);
    end
    check_sb_empty("start");
  endtask

  task automatic test_reset_mid();
    begin_test();
    for (int c = 0; c <= 45; c++) begin
      tick(0, 1'(c == 0 || c == 16), 1'(c == 11 || c == 12),
           1'(c == 12));
      if (c == 13) begin
        n_checks++;
        if ({s_busy, s_done, s_push, s_first, s_mrx, s_mry}
              !== 10'd0 || s_dout !== 64'd0) begin
          n_fail++;
          $display("FAIL mid_reset cyc %0d: got busy%b done%b push%b first%b d%h",
                   c, s_busy, s_done, s_push, s_first, s_dout);
        end
      end
      if (c == 15) begin
        n_checks++;
        if (done_cnt != 0) begin
          n_fail++;
          $display("FAIL mid_nodone: got %0d dones want 0", done_cnt);
        end
      end
      if (c == 18) begin
        n_checks++;
        if (s_first !== 1'b1 || s_dout !== lane(0)) begin
          n_fail++;
          $display("FAIL mid_restart cyc %0d: got first=%b %h",
                   c, s_first, s_dout);
        end
      end
      n_checks++;
      if (s_done !== 1'(c == 43)) begin
        n_fail++;
        $display("FAIL mid_done cyc %0d: got %b", c, s_done);
      end
    end
    check_sb_empty("mid");
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    if_a.stopout = 1'b0;
    if_b.stopout = 1'b0;
    test_reset();
    test_full_stream();
    test_backpressure();
    test_nlanes17();
    test_start_handling();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
